// File: rtl/keccak_padder.sv
// Keccak padder: packs 64-bit message words into rate-sized blocks, applies
// SHA-3 / SHAKE multi-rate padding (domain byte, final 0x80) and hands each
// block to the permutation core with a ready/ack handshake.
module keccak_padder #(
   parameter int W   = 64,
   parameter int BLK = 1344
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [1:0]     mode,
   input  logic [W-1:0]   in,
   input  logic           in_ready,
   input  logic           is_last,
   input  logic [2:0]     byte_num,
   output logic           buffer_full,
   output logic [BLK-1:0] out,
   output logic           out_ready,
   output logic           last_out,
   input  logic           f_ack
);

   typedef enum logic [1:0] {ST_FILL, ST_PAD, ST_FULL} state_t;

   state_t         r_state;
   logic [4:0]     r_cnt;
   logic [1:0]     r_mode;
   logic           r_in_msg;     // a message is in progress; mode is frozen
   logic           r_pad;        // padding already placed in this block
   logic [BLK-1:0] r_out;
   logic           r_out_ready;
   logic           r_last_out;
   logic           r_buffer_full;

   logic [1:0]     w_mode;
   logic [4:0]     w_nw;
   logic [10:0]    w_rate;
   logic [7:0]     w_dom;
   logic           w_last_slot;
   logic           w_accept;
   logic [W-1:0]   w_word;
   logic [BLK-1:0] w_mask;
   logic [BLK-1:0] w_shift;

   assign out         = r_out;
   assign out_ready   = r_out_ready;
   assign last_out    = r_last_out;
   assign buffer_full = r_buffer_full;

   // Rate and domain byte follow the live mode only until a message starts.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      w_mode = r_in_msg ? r_mode : mode;
      w_nw   = 5'd17;
      case (w_mode)
         2'd0:    w_nw = 5'd9;
         2'd2:    w_nw = 5'd21;
         default: w_nw = 5'd17;
      endcase
      w_rate      = {w_nw, 6'b0};
      w_dom       = w_mode[1] ? 8'h1F : 8'h06;
      w_last_slot = (r_cnt == (w_nw - 5'd1));
      w_accept    = (r_state == ST_FILL) && in_ready && !r_buffer_full;
   end

   // Word to shift in: data bytes, domain byte after the final data byte,
   // zero padding, and 0x80 in the block's last byte when it ends the message.
   always_comb begin
      w_word = '0;
      if (r_state == ST_FILL) begin
         for (int b = 0; b < 8; b++) begin
            if (!is_last || (b < int'(byte_num)))
               w_word[63-8*b -: 8] = in[63-8*b -: 8];
            else if (b == int'(byte_num))
               w_word[63-8*b -: 8] = w_dom;
         end
      end
      if (w_last_slot && ((r_state == ST_PAD) || is_last))
         w_word[7:0] = w_word[7:0] | 8'h80;
      // Bits at and above the rate stay zero as the block shifts up.
      w_mask  = ~({BLK{1'b1}} << w_rate);
      w_shift = {r_out[BLK-W-1:0], w_word} & w_mask;
   end

   // Block FSM with registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         // NOTE: the block register is a datapath register, not a memory, and must clear so out=0 after reset.
         r_state       <= ST_FILL;
         r_cnt         <= '0;
         r_mode        <= '0;
         r_in_msg      <= 1'b0;
         r_pad         <= 1'b0;
         r_out         <= '0;
         r_out_ready   <= 1'b0;
         r_last_out    <= 1'b0;
         r_buffer_full <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         case (r_state)
            ST_FILL: begin
               if (w_accept) begin
                  r_out <= w_shift;
                  r_cnt <= r_cnt + 5'd1;
                  if (!r_in_msg) begin
                     r_in_msg <= 1'b1;
                     r_mode   <= mode;
                  end
                  if (w_last_slot) begin
                     r_state       <= ST_FULL;
                     r_out_ready   <= 1'b1;
                     r_buffer_full <= 1'b1;
                     r_last_out    <= is_last | r_pad;
                  end else if (is_last) begin
                     r_state       <= ST_PAD;
                     r_pad         <= 1'b1;
                     r_buffer_full <= 1'b1;
                  end
               end
            end
            ST_PAD: begin
               r_out <= w_shift;
               r_cnt <= r_cnt + 5'd1;
               if (w_last_slot) begin
                  r_state     <= ST_FULL;
                  r_out_ready <= 1'b1;
                  r_last_out  <= 1'b1;
               end
            end
            ST_FULL: begin
               if (f_ack) begin
                  r_state       <= ST_FILL;
                  r_cnt         <= '0;
                  r_out         <= '0;
                  r_out_ready   <= 1'b0;
                  r_last_out    <= 1'b0;
                  r_buffer_full <= 1'b0;
                  r_pad         <= 1'b0;
                  if (r_last_out) r_in_msg <= 1'b0;
               end
            end
            default: r_state <= ST_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_keccak_padder.sv
// Self-checking bench for keccak_padder: a byte-level padding model pushes
// expected blocks to a scoreboard, an ack responder pops and compares them.
module tb_keccak_padder;

   typedef byte unsigned byte_q_t[$];
   typedef struct {
      logic [1343:0] blk;
      logic          last;
   } exp_t;

   logic          clk;
   logic          reset;
   logic [1:0]    mode;
   logic [63:0]   in;
   logic          in_ready;
   logic          is_last;
   logic [2:0]    byte_num;
   logic          buffer_full;
   logic [1343:0] out;
   logic          out_ready;
   logic          last_out;
   logic          f_ack;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   ack_hold = 0;

   keccak_padder dut (
      .clk(clk), .reset(reset), .mode(mode), .in(in), .in_ready(in_ready),
      .is_last(is_last), .byte_num(byte_num), .buffer_full(buffer_full),
      .out(out), .out_ready(out_ready), .last_out(last_out), .f_ack(f_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference padding: message, domain byte, zeros, 0x80 on the final byte.
   task automatic push_expected(input byte_q_t msg, input logic [1:0] m);
      int nw, rb, plen, nblk;
      byte unsigned p[];
      exp_t e;
      nw   = (m == 2'd0) ? 9 : (m == 2'd2) ? 21 : 17;
      rb   = nw * 8;
      plen = ((msg.size() + 1 + rb - 1) / rb) * rb;
      nblk = plen / rb;
      p = new[plen];
      foreach (p[i]) p[i] = 8'h00;
      foreach (msg[i]) p[i] = msg[i];
      p[msg.size()] = m[1] ? 8'h1F : 8'h06;
      p[plen-1] = p[plen-1] | 8'h80;
      for (int j = 0; j < nblk; j++) begin
         e.blk  = '0;
         e.last = (j == nblk - 1);
         for (int i = 0; i < rb; i++) e.blk[nw*64-1-8*i -: 8] = p[j*rb+i];
         sb.push_back(e);
      end
   endtask

   // Presents one word from a negedge and returns at the negedge after acceptance.
   task automatic send_word(input logic [63:0] w, input logic lst, input logic [2:0] bn);
      int bound;
      in = w; is_last = lst; byte_num = bn; in_ready = 1'b1;
      bound = 0;
      while (buffer_full === 1'b1 && bound < 500) begin
         @(negedge clk);
         bound++;
      end
      if (bound >= 500) begin
         n_checks++; n_errors++;
         $display("FAIL send_timeout: buffer_full stuck at %b, required 0 within 500 cycles", buffer_full);
      end
      @(negedge clk);
   endtask

   // Sends a whole message; mode switches to m_after after word switch_idx.
   task automatic send_msg(input byte_q_t msg, input logic [1:0] m,
                           input logic [1:0] m_after, input int switch_idx);
      int nf, bn;
      logic [63:0] w;
      push_expected(msg, m);
      mode = m;
      nf = msg.size() / 8;
      bn = msg.size() % 8;
      for (int k = 0; k <= nf; k++) begin
         w = {$urandom, $urandom};   // junk in unused bytes must be dropped
         for (int b = 0; b < 8; b++)
            if (8*k + b < msg.size()) w[63-8*b -: 8] = msg[8*k+b];
         send_word(w, (k == nf), (k == nf) ? 3'(bn) : 3'd0);
         if (k == switch_idx) mode = m_after;
      end
      in_ready = 1'b0; is_last = 1'b0;
   endtask

   task automatic rand_msg(output byte_q_t msg, input int len);
      msg = {};
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
   endtask

   task automatic wait_drain();
      int bound = 0;
      while ((sb.size() != 0 || out_ready === 1'b1 || f_ack === 1'b1) && bound < 3000) begin
         @(negedge clk);
         bound++;
      end
      n_checks++;
      if (bound >= 3000) begin
         n_errors++;
         $display("FAIL drain_timeout: %0d blocks still expected, required 0", sb.size());
      end
   endtask

   // Ack responder: compares each presented block, optionally holds, then acks.
   initial begin
      exp_t e;
      logic [1343:0] held;
      f_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (f_ack) begin
            f_ack = 1'b0;
            n_checks++;
            if (out_ready !== 1'b0 || buffer_full !== 1'b0 || last_out !== 1'b0 || out !== '0) begin
               n_errors++;
               $display("FAIL post_ack: out_ready=%b buffer_full=%b last_out=%b out_zero=%b, required 0 0 0 1",
                        out_ready, buffer_full, last_out, (out == '0));
            end
         end else if (out_ready === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_block: got block with last_out=%b, required no block", last_out);
            end else begin
               e = sb.pop_front();
               if (out !== e.blk) begin
                  n_errors++;
                  $display("FAIL block_data: got low word %h top word %h, required %h %h",
                           out[63:0], out[1343:1280], e.blk[63:0], e.blk[1343:1280]);
               end
               n_checks++;
               if (last_out !== e.last) begin
                  n_errors++;
                  $display("FAIL block_last: got last_out=%b, required %b", last_out, e.last);
               end
            end
            held = out;
            for (int h = 0; h < ack_hold; h++) begin
               @(negedge clk);
               n_checks++;
               if (out !== held || buffer_full !== 1'b1 || out_ready !== 1'b1) begin
                  n_errors++;
                  $display("FAIL hold_stable: out_stable=%b buffer_full=%b out_ready=%b, required 1 1 1",
                           (out == held), buffer_full, out_ready);
               end
            end
            f_ack = 1'b1;
         end
      end
   end

   task automatic test_reset();
      reset = 1'b0; mode = 2'd0; in = '0; in_ready = 1'b0; is_last = 1'b0; byte_num = 3'd0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (out !== '0 || out_ready !== 1'b0 || last_out !== 1'b0 || buffer_full !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_state: out_zero=%b out_ready=%b last_out=%b buffer_full=%b, required 1 0 0 0",
                  (out == '0), out_ready, last_out, buffer_full);
      end
   endtask

   task automatic test_single_word();
      byte_q_t msg = '{8'h61, 8'h62, 8'h63};
      send_msg(msg, 2'd1, 2'd1, -1);
      wait_drain();
   endtask

   task automatic test_exact_block();
      byte_q_t msg;
      rand_msg(msg, 72);
      send_msg(msg, 2'd0, 2'd0, -1);
      wait_drain();
   endtask

   task automatic test_final_slot();
      byte_q_t msg;
      rand_msg(msg, 167);
      send_msg(msg, 2'd2, 2'd2, -1);
      n_checks++;
      if (out_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL final_slot_latency: out_ready=%b one cycle after last word, required 1", out_ready);
      end
      wait_drain();
   endtask

   task automatic test_ack_hold();
      byte_q_t msg;
      rand_msg(msg, 150);
      ack_hold = 10;
      send_msg(msg, 2'd1, 2'd1, -1);
      wait_drain();
      ack_hold = 0;
   endtask

   task automatic test_mid_reset();
      byte_q_t msg;
      mode = 2'd3;
      for (int k = 0; k < 5; k++) send_word({$urandom, $urandom}, 1'b0, 3'd0);
      in_ready = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      n_checks++;
      if (out !== '0 || buffer_full !== 1'b0 || out_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL mid_reset: out_zero=%b buffer_full=%b out_ready=%b, required 1 0 0",
                  (out == '0), buffer_full, out_ready);
      end
      rand_msg(msg, 20);
      send_msg(msg, 2'd0, 2'd0, -1);
      wait_drain();
   endtask

   task automatic test_mode_toggle();
      byte_q_t msg;
      rand_msg(msg, 90);
      send_msg(msg, 2'd1, 2'd2, 3);
      wait_drain();
   endtask

   task automatic test_back_to_back();
      byte_q_t m1, m2;
      rand_msg(m1, 200);
      rand_msg(m2, 136);
      send_msg(m1, 2'd3, 2'd3, -1);
      send_msg(m2, 2'd2, 2'd2, -1);
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_exact_block();
      test_final_slot();
      test_ack_hold();
      test_mid_reset();
      test_mode_toggle();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/keccak_padder.md
Name: keccak_padder

Overview:
- Upstream stage of the Keccak permutation core.
- Packs a 64-bit message word stream into rate-sized blocks of up to 1344 bits.
- Applies the SHA-3 / SHAKE multi-rate padding (domain byte, then final 0x80).
- Presents each block to the permutation core with a ready/ack handshake and flags the final block of each message, which drives the core's last_in.

Parameters:
- W, 64, input word width in bits; fixed, other values unsupported.
- BLK, 1344, block output width in bits (maximum rate).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (reset==0 clears the block on the next clk edge)
- mode  input  2  0: rate 576 / 9 words, SHA3; 1: rate 1088 / 17 words, SHA3; 2: rate 1344 / 21 words, SHAKE; 3: rate 1088 / 17 words, SHAKE
- in  input  64  message word; first byte in [63:56]
- in_ready  input  1  in is valid
- is_last  input  1  this is the message's final word (qualified by in_ready)
- byte_num  input  3  valid bytes in the final word (0..7); 0 means the final word carries no data
- buffer_full  output  1  1 = block buffer full or padding in progress; input not accepted
- out  output  1344  packed block; word k of block at [R-1-64k -: 64], R = rate; bits [1343:R] are 0
- out_ready  output  1  block valid; connects to core in_ready
- last_out  output  1  current block is the final block of the message; connects to core last_in
- f_ack  input  1  core accepted the block; connects to core ack

Behaviour:
- Reset (reset==0 at clk edge):
  - out=0, out_ready=0, last_out=0, buffer_full=0.
  - Word count cnt=0; state=FILL.
  - Reset mid-block discards partial data.
- Rate words NW: 9, 17, 21, 17 for mode 0..3. Mode is latched on the first accepted word of each message; mode changes mid-message are ignored.
- Domain byte D: 0x06 for modes 0/1, 0x1F for modes 2/3.
- Word accept: a word is accepted when in_ready & ~buffer_full & state==FILL.
  - Accepted word is shifted in: out <= {out[1279:0], word}; cnt++.
  - After NW words, the first word occupies [R-1:R-64]; all bits above R stay 0 (shift is masked to R).
- Final word (is_last=1): stored word is the byte_num data bytes, then byte D at byte position byte_num (byte 0 = [63:56]), then zero bytes.
  - State -> PAD unless this word completes the block.
- Final byte of each message: the last byte of the last word in the block (bits [7:0] of the word at slot NW-1) is ORed with 0x80.
  - If the final word is also slot NW-1 and byte_num=7, that byte is D|0x80 (0x86 or 0x9F).
- PAD state: one all-zero word is shifted per cycle (0x80 applied in slot NW-1) until cnt==NW; in_ready is ignored; buffer_full=1.
- States:
  - FILL -> PAD on is_last with cnt+1 < NW.
  - FILL/PAD -> FULL when cnt reaches NW.
  - FULL -> FILL on f_ack. The message ends if last_out was set.
- FULL state: out_ready=1, buffer_full=1; out is held stable until f_ack.
  - last_out=1 iff this block contains the padding; it is valid while out_ready=1.
- f_ack while FULL: next edge gives cnt=0, out_ready=0, last_out=0, out=0, buffer_full=0.
  - No word is accepted in the ack cycle.
  - Latency from the cycle a block fills to out_ready=1 is one cycle.
- f_ack while not FULL is ignored.
- Message of exactly k·NW bytes: the final word with byte_num=0 still triggers a padding-only block (last_out=1).
- Throughput: in FILL, one word per cycle; a block is presented NW cycles after its first word plus any PAD cycles.

Test Plan:
- Mode 1, one final word in=0x6162630000000000 with is_last=1, byte_num=3 -> one block, out_ready=1, last_out=1. out[1087:1024]=0x6162630600000000, out[63:0]=0x0000000000000080, all other bits 0. After f_ack: out_ready=0, buffer_full=0.
- Mode 0, 9 full words then a final word with byte_num=0 -> block 1 has last_out=0 with the words at [575:512]..[63:0]. After f_ack, block 2 has out[575:512]=0x0600000000000000, out[7:0]=0x80, last_out=1. out[1343:576]=0 in both blocks.
- Mode 2, 20 words then a final word with byte_num=7 at slot 20 -> byte [7:0] of out=0x9F, no PAD cycles, out_ready asserts the next cycle.
- Hold f_ack=0 for 10 cycles with a full block and in_ready=1 -> out stable, buffer_full=1, no words consumed. Assert f_ack -> the next word enters at cnt=0.
- reset=0 asserted after 5 words in mode 3, then a fresh message -> no residue from the first 5 words in out. The new message latches the new mode.
- Toggle mode mid-message (1->2) -> block length stays 17 words and padding D=0x06.
